// File: rtl/idex_issue_stage.sv
// ID/EX issue register: decodes a RISC-V ALU/load/store/branch instruction, resolves operand forwarding, registers the result.
// Latency: one clock from capture (in_valid && in_ready) to registered outputs.
// Backpressure: single-entry skid-free register; in_ready drops while full and not drained, or during flush; outputs frozen on stall.
module idex_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,

    input  logic            fwd_mem_en,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_en,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,

    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [2:0]      alu_ctrl,
    output logic [4:0]      rd_out,
    output logic            reg_write,
    output logic            illegal
);

    // Major opcodes handled by this stage
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation encodings driven on alu_ctrl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Everything the execute stage sees, kept together so capture/hold/reset act on one word
    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [2:0]      alu_ctrl;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } issue_t;

    issue_t          dec;
    issue_t          held;
    logic            held_vld;
    logic            capture;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [2:0]      f3_alu;
    logic            f3_ok;

    // Accept when the slot is empty or being drained this cycle; flush blocks acceptance
    assign in_ready = (!held_vld || out_ready) && !flush;
    assign capture  = in_valid && in_ready;

    // Operand A bypass: MEM result is younger than WB, so it wins; x0 is hard-wired and never bypassed
    always_comb begin
        fwd_a = rs1_data;
        if (rs1_addr != 5'd0) begin
            if (fwd_mem_en && (fwd_mem_rd == rs1_addr)) begin
                fwd_a = fwd_mem_data;
            end else if (fwd_wb_en && (fwd_wb_rd == rs1_addr)) begin
                fwd_a = fwd_wb_data;
            end
        end
    end

    // Operand B bypass, same priority as operand A
    always_comb begin
        fwd_b = rs2_data;
        if (rs2_addr != 5'd0) begin
            if (fwd_mem_en && (fwd_mem_rd == rs2_addr)) begin
                fwd_b = fwd_mem_data;
            end else if (fwd_wb_en && (fwd_wb_rd == rs2_addr)) begin
                fwd_b = fwd_wb_data;
            end
        end
    end

    // funct3 to ALU op for the register/immediate arithmetic groups; bit 30 only selects SUB for R-type
    always_comb begin
        f3_ok  = 1'b1;
        f3_alu = ALU_ADD;
        case (funct3)
            3'b000:  f3_alu = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  f3_alu = ALU_AND;
            3'b110:  f3_alu = ALU_OR;
            3'b010:  f3_alu = ALU_SLT;
            default: f3_ok  = 1'b0;
        endcase
    end

    // Main decode: operand B source, ALU op, write enable and illegal flag
    always_comb begin
        dec           = '0;
        dec.src_a     = fwd_a;
        dec.src_b     = fwd_b;
        dec.rd        = rd_addr;
        dec.alu_ctrl  = ALU_ADD;
        dec.reg_write = 1'b0;
        dec.illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                dec.alu_ctrl  = f3_alu;
                dec.reg_write = 1'b1;
                dec.illegal   = !f3_ok;
            end
            OP_I: begin
                dec.src_b     = imm;
                dec.alu_ctrl  = f3_alu;
                dec.reg_write = 1'b1;
                dec.illegal   = !f3_ok;
            end
            OP_LOAD: begin
                dec.src_b     = imm;
                dec.reg_write = 1'b1;
            end
            OP_STORE: begin
                dec.src_b     = imm;
            end
            OP_BRANCH: begin
                dec.alu_ctrl  = ALU_SUB;
            end
            default: begin
                dec.illegal   = 1'b1;
            end
        endcase
        // Illegal instructions still flow down the pipe but must be architecturally inert
        if (dec.illegal) begin
            dec.alu_ctrl  = ALU_ADD;
            dec.reg_write = 1'b0;
        end
        // Writes to x0 are discarded here so later stages need not special-case it
        if (rd_addr == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    // Issue register: flush beats everything, then capture, then drain; otherwise hold (stall)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_vld <= 1'b0;
            held     <= '0;
        end else if (flush) begin
            held_vld <= 1'b0;
        end else if (capture) begin
            held_vld <= 1'b1;
            held     <= dec;
        end else if (out_ready) begin
            held_vld <= 1'b0;
        end
    end

    assign out_valid = held_vld;
    assign src_a     = held.src_a;
    assign src_b     = held.src_b;
    assign alu_ctrl  = held.alu_ctrl;
    assign rd_out    = held.rd;
    assign reg_write = held.reg_write;
    assign illegal   = held.illegal;

endmodule

// File: tb/tb_idex_issue_stage.sv
// Bench for idex_issue_stage: directed scenarios followed by random traffic against a reference model.
// Latency: model predicts outputs one clock after capture.
// Backpressure: model tracks stall/drain/flush to predict in_ready and held outputs.
module tb_idex_issue_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic            fwd_mem_en, fwd_wb_en;
    logic [4:0]      fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] src_a, src_b;
    logic [2:0]      alu_ctrl;
    logic [4:0]      rd_out;
    logic            reg_write;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the execute stage should currently see
    logic            m_valid;
    logic [XLEN-1:0] m_a, m_b;
    logic [2:0]      m_alu;
    logic [4:0]      m_rd;
    logic            m_rw, m_ill, m_b_known;

    idex_issue_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl), .rd_out(rd_out),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value an operand register reads as, after bypassing
    function automatic logic [XLEN-1:0] ref_fwd(input logic [4:0] r, input logic [XLEN-1:0] rf);
        if (r == 0) return rf;
        if (fwd_mem_en && fwd_mem_rd == r) return fwd_mem_data;
        if (fwd_wb_en && fwd_wb_rd == r) return fwd_wb_data;
        return rf;
    endfunction

    // Instruction semantics straight from the opcode/funct3 tables
    task automatic ref_capture();
        bit is_r, is_i, is_ld, is_st, is_br, arith, known, f3_legal;
        is_r  = (opcode == 7'b0110011);
        is_i  = (opcode == 7'b0010011);
        is_ld = (opcode == 7'b0000011);
        is_st = (opcode == 7'b0100011);
        is_br = (opcode == 7'b1100011);
        arith = is_r || is_i;
        known = arith || is_ld || is_st || is_br;
        f3_legal = (funct3 == 0) || (funct3 == 7) || (funct3 == 6) || (funct3 == 2);
        m_ill = !known || (arith && !f3_legal);
        if (m_ill)                    m_alu = 3'd0;
        else if (is_br)               m_alu = 3'd1;
        else if (!arith)              m_alu = 3'd0;
        else if (funct3 == 7)         m_alu = 3'd2;
        else if (funct3 == 6)         m_alu = 3'd3;
        else if (funct3 == 2)         m_alu = 3'd5;
        else                          m_alu = (is_r && funct7b5) ? 3'd1 : 3'd0;
        m_rw      = !m_ill && (arith || is_ld) && (rd_addr != 0);
        m_rd      = rd_addr;
        m_a       = ref_fwd(rs1_addr, rs1_data);
        m_b       = (is_i || is_ld || is_st) ? imm : ref_fwd(rs2_addr, rs2_data);
        m_b_known = known;
        m_valid   = 1'b1;
    endtask

    function automatic logic ref_ready();
        return (!m_valid || out_ready) && !flush;
    endfunction

    task automatic ref_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_alu = 0; m_rd = 0; m_rw = 0; m_ill = 0; m_b_known = 1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_src_a"}, src_a, 0);
        chk({tag, "_src_b"}, src_b, 0);
        chk({tag, "_alu"}, alu_ctrl, 0);
        chk({tag, "_rd"}, rd_out, 0);
        chk({tag, "_rw"}, reg_write, 0);
        chk({tag, "_ill"}, illegal, 0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, m_valid);
        if (m_valid) begin
            chk({tag, "_src_a"}, src_a, m_a);
            if (m_b_known) chk({tag, "_src_b"}, src_b, m_b);
            chk({tag, "_alu"}, alu_ctrl, m_alu);
            chk({tag, "_rd"}, rd_out, m_rd);
            chk({tag, "_rw"}, reg_write, m_rw);
            chk({tag, "_ill"}, illegal, m_ill);
        end
    endtask

    // Inputs are set at the falling edge; check in_ready, advance the model, clock, then check outputs
    task automatic step(input string tag);
        #1;
        chk({tag, "_in_ready"}, in_ready, ref_ready());
        if (flush)                        m_valid = 0;
        else if (in_valid && ref_ready()) ref_capture();
        else if (out_ready)               m_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input logic [XLEN-1:0] im);
        opcode = op; funct3 = f3; funct7b5 = f7;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        rs1_data = d1; rs2_data = d2; imm = im;
    endtask

    logic [6:0] op_pool [7];

    initial begin
        op_pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111, 7'b0110111};
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
        fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
        fwd_mem_data = 0; fwd_wb_data = 0;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0);
        ref_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1;

        // R-type subtract
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0);
        in_valid = 1; out_ready = 1;
        step("rsub");
        chk("rsub_alu_lit", alu_ctrl, 3'b001);
        chk("rsub_src_b_lit", src_b, 32'd3);

        // Forward priority: MEM over WB, and x0 never bypassed
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd7, 5'd0, 5'd9, 32'h11, 32'h22, 32'd0);
        fwd_mem_en = 1; fwd_mem_rd = 7; fwd_mem_data = 32'hAA;
        fwd_wb_en = 1;  fwd_wb_rd = 7;  fwd_wb_data = 32'hBB;
        step("fwd_mem");
        chk("fwd_mem_lit", src_a, 32'hAA);
        rs1_addr = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
        step("fwd_x0");
        chk("fwd_x0_lit", src_a, 32'h11);
        fwd_wb_rd = 9; fwd_mem_rd = 4; rs1_addr = 9; rs2_addr = 4;
        step("fwd_wb");
        fwd_mem_en = 0; fwd_wb_en = 0;

        // Stall: three cycles of frozen outputs while inputs keep changing
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_instr(7'b0010011, 3'b111, 1'b0, 5'd3, 5'd4, 5'd6, $urandom, $urandom, $urandom);
            step("stall");
        end
        out_ready = 1;
        step("unstall");

        // Flush with a held instruction and a new one offered
        flush = 1;
        set_instr(7'b0000011, 3'b010, 1'b0, 5'd2, 5'd3, 5'd8, 32'h100, 32'h5, 32'h20);
        step("flush");
        flush = 0;
        step("post_flush");

        // Illegal opcode, then I-type SLT with all-ones immediate
        set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        step("illegal");
        chk("illegal_lit", illegal, 1'b1);
        set_instr(7'b0010011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'hFFFF_FFFF);
        step("islt");
        chk("islt_src_b_lit", src_b, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a stall, between clock edges
        out_ready = 0;
        step("pre_areset");
        #2 rst_n = 0;
        #1;
        ref_reset();
        check_zero("areset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; in_valid = 0;
        step("after_reset_idle");
        in_valid = 1; out_ready = 1;
        set_instr(7'b0100011, 3'b010, 1'b0, 5'd5, 5'd6, 5'd7, 32'h40, 32'h50, 32'h8);
        step("after_reset_cap");

        // Random traffic: small register range to exercise bypass hits
        for (int i = 0; i < 600; i++) begin
            set_instr(op_pool[$urandom_range(0, 6)], 3'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom);
            fwd_mem_en = 1'($urandom); fwd_mem_rd = 5'($urandom_range(0, 3)); fwd_mem_data = $urandom;
            fwd_wb_en  = 1'($urandom); fwd_wb_rd  = 5'($urandom_range(0, 3)); fwd_wb_data  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_issue_stage.md
IDEX_ISSUE_STAGE -- requirements
Module: idex_issue_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width of operands and forwarded data.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream holds a decoded instruction.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 opcode  input  7  RISC-V major opcode.
REQ-007 funct3  input  3  RISC-V funct3.
REQ-008 funct7b5  input  1  instruction bit 30.
REQ-009 rs1_addr, rs2_addr, rd_addr  input  5 each  register specifiers.
REQ-010 rs1_data, rs2_data, imm  input  XLEN each  register-file reads and sign-extended immediate.
REQ-011 fwd_mem_en, fwd_wb_en  input  1 each  MEM / WB stage will write a register.
REQ-012 fwd_mem_rd, fwd_wb_rd  input  5 each  MEM / WB destination registers.
REQ-013 fwd_mem_data, fwd_wb_data  input  XLEN each  MEM / WB write-back values.
REQ-014 flush  input  1  discard held and incoming instruction.
REQ-015 out_ready  input  1  execute stage consumes this cycle.
REQ-016 out_valid  output  1  registered outputs hold a valid instruction.
REQ-017 src_a, src_b  output  XLEN each  ALU operands A and B.
REQ-018 alu_ctrl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than.
REQ-019 rd_out  output  5  destination register.
REQ-020 reg_write  output  1  instruction writes rd.
REQ-021 illegal  output  1  unsupported opcode/funct3.

Function
REQ-022 All outputs SHALL be registered; capture-to-output latency is exactly one clock.
REQ-023 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-024 Capture SHALL occur when in_valid && in_ready; on capture out_valid goes 1.
REQ-025 When out_valid && out_ready and no capture, out_valid SHALL go 0 next cycle.
REQ-026 When out_valid && !out_ready, all outputs SHALL hold unchanged (stall).
REQ-027 flush SHALL clear out_valid next cycle and suppress any capture that cycle; flush wins over in_valid and out_ready.
REQ-028 Decode: 0110011 R-type, src_b = fwd(rs2); 0010011 I-ALU, src_b = imm; 0000011 load and 0100011 store: alu_ctrl 000, src_b = imm; 1100011 branch: alu_ctrl 001, src_b = fwd(rs2).
REQ-029 R/I funct3: 000 -> 000, except R-type with funct7b5=1 -> 001; 111 -> 010; 110 -> 011; 010 -> 101.
REQ-030 Any other opcode or R/I funct3 SHALL set illegal=1, alu_ctrl=000, reg_write=0; out_valid still asserts.
REQ-031 reg_write SHALL be 1 for R, I-ALU and load when legal; 0 for store, branch, illegal, and whenever rd_addr=0.
REQ-032 src_a SHALL be fwd(rs1).
REQ-033 fwd(r): fwd_mem_data if fwd_mem_en && fwd_mem_rd==r && r!=0; else fwd_wb_data if fwd_wb_en && fwd_wb_rd==r && r!=0; else the register-file value.
REQ-034 Forwarding SHALL be evaluated only in the capture cycle; held operands do not re-forward during stall.
REQ-035 Register x0 SHALL never be forwarded; rs=0 always yields rs1_data/rs2_data.

Reset
REQ-036 rst_n low SHALL immediately force out_valid=0, src_a=0, src_b=0, alu_ctrl=000, rd_out=0, reg_write=0, illegal=0.
REQ-037 Reset asserted mid-stall SHALL drop the held instruction; after release in_ready=1 and the first capture needs a fresh in_valid.

Verification
REQ-038 R-type sub: opcode 0110011, funct3 000, funct7b5 1, rs1_data 10, rs2_data 3, rd 5, out_ready 1 -> next cycle out_valid 1, alu_ctrl 001, src_a 10, src_b 3, rd_out 5, reg_write 1.
REQ-039 Forward priority: rs1=7 with fwd_mem_rd=7 data 0xAA and fwd_wb_rd=7 data 0xBB, both enabled -> src_a 0xAA; with rs1=0 and both rd=0 enabled -> src_a = rs1_data.
REQ-040 Stall: out_ready 0 for 3 cycles with in_valid 1 and changing inputs -> outputs frozen, in_ready 0; out_ready 1 -> next instruction captured following edge.
REQ-041 Flush with in_valid 1 and out_valid 1 -> next cycle out_valid 0, no capture; following cycle normal capture resumes.
REQ-042 Illegal: opcode 1111111 -> out_valid 1, illegal 1, reg_write 0, alu_ctrl 000; I-type funct3 010 imm 0xFFFFFFFF -> alu_ctrl 101, src_b 0xFFFFFFFF.
REQ-043 Async reset: drop rst_n between clock edges while out_valid 1 -> out_valid 0 before next edge, all outputs zero.
